// File: rtl/mcu_ddr_pkg.sv
// Shared MCU/DDR definitions: arbiter state encodings, controller command codes, requester indices.
package mcu_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
  localparam logic [2:0] DDR_CMD_READ  = 3'b001;

  localparam logic [1:0] REQ_PSC = 2'd0;
  localparam logic [1:0] REQ_DSC = 2'd1;
  localparam logic [1:0] REQ_L2  = 2'd2;

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin selector; zero latency, no flow control.
// Priority order is ptr+1, ptr+2, ptr (mod 3); gnt is one-hot or zero.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] index
);

  always_comb begin
    logic [2:0] cand;
    gnt   = '0;
    index = '0;
    cand  = '0;
    // Walk lowest priority first so the last hit is the highest-priority requester.
    for (int k = 3; k >= 1; k--) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req[cand[1:0]]) begin
        gnt   = 3'b001 << cand[1:0];
        index = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Round-robin owner of the DDR3 user port for psc/dsc/l2; grant one cycle after a request is sampled.
// Command held until i_ddr_op_rdy; burst paced by i_ddr_beat_vld; i_ddr_ready low aborts to IDLE.
module ddr_req_arbiter
  import mcu_ddr_pkg::*;
#(
  parameter int BURST_LENTH = 8,
  parameter int ADDR_W      = 28,
  parameter int NUM_REQ     = 3
) (
  input  logic                      clk_166M66,
  input  logic                      mcu_sys_rst,
  input  logic                      i_ddr_ready,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_ddr_op_en,
  output logic [2:0]                o_ddr_op_cmd,
  output logic [ADDR_W-1:0]         o_ddr_op_addr,
  input  logic                      i_ddr_op_rdy,
  input  logic                      i_ddr_beat_vld,
  output logic                      o_busy
);

  localparam int BEAT_W = $clog2(BURST_LENTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENTH - 1);

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [NUM_REQ-1:0]  grant_q;
  logic [2:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          pick_gnt;
  logic [1:0]          pick_idx;
  logic                do_grant, do_accept, do_beat, do_release;

  rr_pick3 u_pick (
    .req   (i_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .index (pick_idx)
  );

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_grant    = 1'b0;
    do_accept   = 1'b0;
    do_beat     = 1'b0;
    do_release  = 1'b0;
    o_ddr_op_en = (state == ST_ISSUE);
    o_busy      = (state != ST_IDLE);
    o_done      = (state == ST_DONE) ? grant_q : '0;
    // Losing calibration wins over any handshake in the same cycle.
    case (state)
      ST_IDLE: begin
        if (i_ddr_ready && |i_req) begin
          state_nxt = ST_ISSUE;
          do_grant  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!i_ddr_ready) begin
          state_nxt  = ST_IDLE;
          do_release = 1'b1;
        end else if (i_ddr_op_rdy) begin
          state_nxt = ST_XFER;
          do_accept = 1'b1;
        end
      end
      ST_XFER: begin
        if (!i_ddr_ready) begin
          state_nxt  = ST_IDLE;
          do_release = 1'b1;
        end else if (i_ddr_beat_vld) begin
          do_beat = 1'b1;
          if (beat_cnt == LAST_BEAT) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt  = ST_IDLE;
        do_release = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      rr_ptr   <= REQ_L2;
      beat_cnt <= '0;
      grant_q  <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
    end else begin
      if (do_grant) begin
        grant_q <= pick_gnt;
        rr_ptr  <= pick_idx;
        cmd_q   <= i_rw[pick_idx] ? DDR_CMD_WRITE : DDR_CMD_READ;
        addr_q  <= i_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      end
      if (do_release) grant_q <= '0;
      if (do_accept)  beat_cnt <= '0;
      if (do_beat)    beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  assign o_grant       = grant_q;
  assign o_ddr_op_cmd  = cmd_q;
  assign o_ddr_op_addr = addr_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Scoreboarded bench for ddr_req_arbiter: directed requester/controller sequences feed an expectation queue.
module tb_ddr_req_arbiter;

  localparam int AW = 28;
  localparam int BL = 8;
  localparam logic [AW-1:0] A0 = 28'h100_0000;
  localparam logic [AW-1:0] A1 = 28'h020_0040;
  localparam logic [AW-1:0] A2 = 28'h0AB_CDEF;
  localparam logic [AW-1:0] B1 = 28'h0FF_FFFF;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic          clk = 1'b0;
  logic          rst;
  logic          ddr_ready;
  logic [2:0]    req, rw;
  logic [3*AW-1:0] addr;
  logic [2:0]    grant, done;
  logic          op_en, op_rdy, beat_vld, busy;
  logic [2:0]    op_cmd;
  logic [AW-1:0] op_addr;

  ddr_req_arbiter dut (
    .clk_166M66    (clk),
    .mcu_sys_rst   (rst),
    .i_ddr_ready   (ddr_ready),
    .i_req         (req),
    .i_rw          (rw),
    .i_addr        (addr),
    .o_grant       (grant),
    .o_done        (done),
    .o_ddr_op_en   (op_en),
    .o_ddr_op_cmd  (op_cmd),
    .o_ddr_op_addr (op_addr),
    .i_ddr_op_rdy  (op_rdy),
    .i_ddr_beat_vld(beat_vld),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [2:0]    g;
    logic [2:0]    cmd;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   in_issue = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_grant(input logic [2:0] g, input logic [2:0] cmd, input logic [AW-1:0] a);
    exp_t e;
    e.is_done = 1'b0; e.g = g; e.cmd = cmd; e.a = a;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] g);
    exp_t e;
    e.is_done = 1'b1; e.g = g; e.cmd = '0; e.a = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every new command and every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (op_en && !in_issue) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {63'd0, op_en}, 64'd0);
      end else begin
        cur = exp_q.pop_front();
        check("cmd_kind", {63'd0, cur.is_done}, 64'd0);
        check("cmd_grant_cmd_addr", {grant, op_cmd, op_addr}, {cur.g, cur.cmd, cur.a});
      end
      in_issue = 1'b1;
    end else if (op_en) begin
      check("cmd_stable", {grant, op_cmd, op_addr}, {cur.g, cur.cmd, cur.a});
    end
    if (!op_en) in_issue = 1'b0;
    if (|done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {61'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_kind", {63'd0, e.is_done}, 64'd1);
        check("done_vec", {61'd0, done}, {61'd0, e.g});
        check("grant_held_in_done", {61'd0, grant}, {61'd0, e.g});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Controller model: accept after rdy_dly cycles, then stream nbeats beats back to back.
  task automatic serve(input int rdy_dly, input int nbeats);
    int t;
    t = 0;
    while (!op_en && t < 50) begin
      tick();
      t++;
    end
    check("op_en_seen", {63'd0, op_en}, 64'd1);
    if (op_en) begin
      repeat (rdy_dly) tick();
      op_rdy = 1'b1;
      tick();
      op_rdy = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
        beat_vld = 1'b1;
        tick();
        beat_vld = 1'b0;
        if (i == BL - 2) check("no_early_done", {61'd0, done}, 64'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, got running, expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ddr_ready = 1'b0; req = '0; rw = '0;
    addr = {A2, A1, A0}; op_rdy = 1'b0; beat_vld = 1'b0;
    do_reset();
    check("reset_outputs", {grant, done, op_en, op_cmd, op_addr, busy}, 64'd0);

    // Lone psc read, controller accepts two cycles late.
    ddr_ready = 1'b1;
    push_grant(3'b001, CMD_RD, A0);
    push_done(3'b001);
    req = 3'b001;
    tick();
    check("lone_grant_latency", {grant, op_en}, {3'b001, 1'b1});
    serve(2, BL);
    req = 3'b000;
    tick();
    check("lone_grant_clears", {grant, busy}, 64'd0);

    // Round robin from reset with all three requesting.
    do_reset();
    push_grant(3'b001, CMD_RD, A0); push_done(3'b001);
    push_grant(3'b010, CMD_RD, A1); push_done(3'b010);
    push_grant(3'b100, CMD_RD, A2); push_done(3'b100);
    push_grant(3'b001, CMD_RD, A0); push_done(3'b001);
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      serve(0, BL);
      if (k == 3) req = 3'b000;
      tick();
      check("rr_idle_gap", {grant, busy}, 64'd0);
      if (k < 3) begin
        tick();
        check("rr_regrant_after_one_idle", {63'd0, op_en}, 64'd1);
      end
    end

    // l2 write.
    rw = 3'b100;
    push_grant(3'b100, CMD_WR, A2);
    push_done(3'b100);
    req = 3'b100;
    serve(0, BL);
    req = 3'b000;
    rw = 3'b000;
    tick();

    // Abort after 3 beats; ready-low also beats a coincident beat.
    push_grant(3'b010, CMD_RD, A1);
    req = 3'b010;
    serve(0, 3);
    ddr_ready = 1'b0;
    beat_vld = 1'b1;
    tick();
    beat_vld = 1'b0;
    check("abort_outputs", {grant, op_en, busy}, 64'd0);
    tick();
    check("no_grant_when_not_ready", {grant, busy}, 64'd0);
    push_grant(3'b010, CMD_RD, A1);
    push_done(3'b010);
    ddr_ready = 1'b1;
    serve(0, BL);
    req = 3'b000;
    tick();

    // Requester drops and changes its inputs right after the grant.
    push_grant(3'b010, CMD_RD, A1);
    push_done(3'b010);
    req = 3'b010;
    tick();
    req = 3'b000;
    rw = 3'b010;
    addr = {A2, B1, A0};
    serve(1, BL);
    tick();
    rw = 3'b000;
    addr = {A2, A1, A0};

    // Reset mid-burst restores rr_ptr so psc beats dsc (rr_ptr was psc before reset).
    push_grant(3'b001, CMD_RD, A0);
    req = 3'b001;
    serve(0, 3);
    req = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_xfer_outputs", {grant, done, op_en, op_cmd, op_addr, busy}, 64'd0);
    push_grant(3'b001, CMD_RD, A0);
    push_done(3'b001);
    req = 3'b011;
    tick();
    check("post_reset_psc_wins", {61'd0, grant}, 64'd1);
    serve(0, BL);
    req = 3'b000;
    repeat (3) tick();

    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
